// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - FIR coefficient loader: handshake in, banked RAM writes out, update flag on 600 kHz boundaries
// Optional running coefficient checksum on oChecksum when COEFF_CHECKSUM_EN is defined.
module fir_coeff_loader #(
  parameter int NUM_TAPS      = 40,
  parameter int TAPS_PER_BANK = 10,
  parameter int BANK_STRIDE   = 16,
  parameter int DW            = 16,
  parameter int AW            = 6
) (
  input  logic          iClk12M,
  input  logic          iRst,
  input  logic          iEnSample600k,
  input  logic          iLoadReq,
  input  logic          iAbort,
  input  logic          iCoeffValid,
  input  logic [DW-1:0] iCoeffData,
  output logic          oCoeffReady,
  output logic          oCoeffUpdateFlag,
  output logic          oCsnRam,
  output logic          oWrnRam,
  output logic [AW-1:0] oAddrRam,
  output logic [DW-1:0] oWrDtRam,
  output logic          oBusy,
  output logic          oDone,
  output logic          oAborted
`ifdef COEFF_CHECKSUM_EN
  ,
  output logic [DW-1:0] oChecksum
`endif
);

  typedef enum logic [2:0] {IDLE, WAIT_SYNC, ACCEPT, WRITE, GAP, RELEASE} state_t;

  localparam int            NUM_BANKS   = NUM_TAPS / TAPS_PER_BANK;
  localparam logic [AW-1:0] LAST_OFFSET = AW'(TAPS_PER_BANK - 1);
  localparam logic [AW-1:0] LAST_BANK   = AW'(NUM_BANKS - 1);
  localparam logic [AW-1:0] STRIDE      = AW'(BANK_STRIDE);

  state_t        state;
  logic [AW-1:0] bank;
  logic [AW-1:0] offset;

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state            <= IDLE;
      bank             <= '0;
      offset           <= '0;
      oCoeffReady      <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oCsnRam          <= 1'b1;
      oWrnRam          <= 1'b1;
      oAddrRam         <= '0;
      oWrDtRam         <= '0;
      oBusy            <= 1'b0;
      oDone            <= 1'b0;
      oAborted         <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
      oChecksum        <= '0;
`endif
    end else begin
      oDone    <= 1'b0;
      oAborted <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
      // The write in WRITE always lands, even if an abort arrives in the same cycle.
      if (state == WRITE)
        oChecksum <= oChecksum + oWrDtRam;
      else if (state == IDLE && iLoadReq && !iAbort)
        oChecksum <= '0;
`endif
      if (iAbort && state != IDLE) begin
        state            <= IDLE;
        oCoeffReady      <= 1'b0;
        oCoeffUpdateFlag <= 1'b0;
        oCsnRam          <= 1'b1;
        oWrnRam          <= 1'b1;
        oBusy            <= 1'b0;
        oAborted         <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (iLoadReq && !iAbort) begin
              state  <= WAIT_SYNC;
              bank   <= '0;
              offset <= '0;
              oBusy  <= 1'b1;
            end
          end
          WAIT_SYNC: begin
            if (iEnSample600k) begin
              state            <= ACCEPT;
              oCoeffUpdateFlag <= 1'b1;
              oCoeffReady      <= 1'b1;
            end
          end
          ACCEPT: begin
            if (iCoeffValid && oCoeffReady) begin
              state       <= WRITE;
              oCoeffReady <= 1'b0;
              oCsnRam     <= 1'b0;
              oWrnRam     <= 1'b0;
              oAddrRam    <= bank * STRIDE + offset;
              oWrDtRam    <= iCoeffData;
            end
          end
          WRITE: begin
            state   <= GAP;
            oCsnRam <= 1'b1;
            oWrnRam <= 1'b1;
          end
          GAP: begin
            if (offset == LAST_OFFSET) begin
              offset <= '0;
              bank   <= bank + 1'b1;
              if (bank == LAST_BANK) begin
                state <= RELEASE;
              end else begin
                state       <= ACCEPT;
                oCoeffReady <= 1'b1;
              end
            end else begin
              offset      <= offset + 1'b1;
              state       <= ACCEPT;
              oCoeffReady <= 1'b1;
            end
          end
          RELEASE: begin
            if (iEnSample600k) begin
              state            <= IDLE;
              oCoeffUpdateFlag <= 1'b0;
              oBusy            <= 1'b0;
              oDone            <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - directed bench for fir_coeff_loader
module tb_fir_coeff_loader;
  localparam int DW = 16;
  localparam int AW = 6;

  logic          iClk12M = 1'b0;
  logic          iRst = 1'b1;
  logic          iEnSample600k = 1'b0;
  logic          iLoadReq = 1'b0;
  logic          iAbort = 1'b0;
  logic          iCoeffValid = 1'b0;
  logic [DW-1:0] iCoeffData = '0;
  logic          oCoeffReady, oCoeffUpdateFlag, oCsnRam, oWrnRam, oBusy, oDone, oAborted;
  logic [AW-1:0] oAddrRam;
  logic [DW-1:0] oWrDtRam;
`ifdef COEFF_CHECKSUM_EN
  logic [DW-1:0] oChecksum;
`endif

  fir_coeff_loader dut (
    .iClk12M(iClk12M), .iRst(iRst), .iEnSample600k(iEnSample600k), .iLoadReq(iLoadReq),
    .iAbort(iAbort), .iCoeffValid(iCoeffValid), .iCoeffData(iCoeffData),
    .oCoeffReady(oCoeffReady), .oCoeffUpdateFlag(oCoeffUpdateFlag), .oCsnRam(oCsnRam),
    .oWrnRam(oWrnRam), .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam), .oBusy(oBusy),
    .oDone(oDone), .oAborted(oAborted)
`ifdef COEFF_CHECKSUM_EN
    , .oChecksum(oChecksum)
`endif
  );

  always #5 iClk12M = ~iClk12M;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [DW-1:0] coef[40];
  logic [AW-1:0] wrAddr[$];
  logic [DW-1:0] wrData[$];
  int doneCnt = 0, abortCnt = 0, flagErr = 0, dblErr = 0, readyErr = 0, hsErr = 0, flagHigh = 0;

  // Sample strobe: one cycle in every 20, changed just after the rising edge.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge iClk12M); #1;
      phase = (phase == 19) ? 0 : phase + 1;
      iEnSample600k = (phase == 0);
    end
  end

  // Protocol monitor sampled on the falling edge.
  initial begin
    logic prevStrobe, prevFlag, prevCsn, prevHs, prevRst;
    prevStrobe = 0; prevFlag = 0; prevCsn = 1; prevHs = 0; prevRst = 1;
    forever begin
      @(negedge iClk12M);
      if (!oCsnRam) begin
        wrAddr.push_back(oAddrRam);
        wrData.push_back(oWrDtRam);
        if (!prevCsn) dblErr++;
      end
      if (oWrnRam != oCsnRam) dblErr++;
      if (!iRst && !prevRst && ((!oCsnRam) != prevHs)) hsErr++;
      if (oCoeffReady && (!oCsnRam || !oCoeffUpdateFlag || !oBusy)) readyErr++;
      if (oCoeffUpdateFlag != prevFlag && !prevStrobe && !oAborted && !iRst && !prevRst) flagErr++;
      if (oDone && (oCoeffUpdateFlag || !prevFlag)) flagErr++;
      if (oDone) doneCnt++;
      if (oAborted) abortCnt++;
      if (oCoeffUpdateFlag) flagHigh++;
      prevStrobe = iEnSample600k;
      prevFlag   = oCoeffUpdateFlag;
      prevCsn    = oCsnRam;
      prevHs     = iCoeffValid && oCoeffReady;
      prevRst    = iRst;
    end
  end

  task automatic tick();
    @(posedge iClk12M); #1;
  endtask

  function automatic logic [AW-1:0] addrOf(input int i);
    return AW'((i / 10) * 16 + (i % 10));
  endfunction

  // pattern 0: valid held high; pattern 1: valid toggles every 4 cycles plus stray iLoadReq pulses
  task automatic runLoad(input int pattern, input int abortAfter);
    int idx, cyc, startDone;
    logic hsNow;
    idx = 0; cyc = 0; startDone = doneCnt;
    wrAddr.delete(); wrData.delete(); flagHigh = 0;
    tick();
    iLoadReq = 1'b1; iCoeffData = coef[0]; iCoeffValid = 1'b1;
    while (doneCnt == startDone && cyc < 1000) begin
      hsNow = iCoeffValid && oCoeffReady;
      tick();
      cyc++;
      if (hsNow) idx++;
      iLoadReq    = (pattern == 1 && idx < 35 && cyc % 7 == 3);
      iCoeffData  = coef[(idx < 40) ? idx : 39];
      iCoeffValid = (pattern == 0) ? 1'b1 : ((cyc / 4) % 2 == 0);
      if (abortAfter > 0 && wrAddr.size() == abortAfter) begin
        iAbort = 1'b1;
        break;
      end
    end
    iLoadReq = 1'b0;
    if (abortAfter == 0) begin
      iCoeffValid = 1'b0;
      checkVal("loadCompleted", 32'(doneCnt - startDone), 32'd1);
    end
  endtask

  task automatic checkAllWrites(input string tag);
    int errs;
    errs = 0;
    checkVal({tag, "_count"}, 32'(wrAddr.size()), 32'd40);
    for (int i = 0; i < 40 && i < wrAddr.size(); i++) begin
      if (wrAddr[i] !== addrOf(i) || wrData[i] !== coef[i]) errs++;
    end
    checkVal({tag, "_addrData"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int n, a0;
    logic [DW-1:0] sum;
    for (int i = 0; i < 40; i++) coef[i] = 16'(i * 97 - 1500);
    coef[0] = 16'd146; coef[1] = 16'd0; coef[2] = 16'hFF0E; coef[3] = 16'd302;

    // reset state
    repeat (3) tick();
    @(negedge iClk12M);
    checkVal("rst_csn", 32'(oCsnRam), 32'd1);
    checkVal("rst_wrn", 32'(oWrnRam), 32'd1);
    checkVal("rst_addr", 32'(oAddrRam), 32'd0);
    checkVal("rst_data", 32'(oWrDtRam), 32'd0);
    checkVal("rst_flagReadyBusy", {29'd0, oCoeffUpdateFlag, oCoeffReady, oBusy}, 32'd0);
    checkVal("rst_doneAborted", {30'd0, oDone, oAborted}, 32'd0);
    tick(); iRst = 1'b0;

    // abort and load request together in IDLE: abort wins silently
    tick(); iAbort = 1'b1; iLoadReq = 1'b1;
    tick(); iAbort = 1'b0; iLoadReq = 1'b0;
    @(negedge iClk12M);
    checkVal("idleAbort_busy", 32'(oBusy), 32'd0);
    checkVal("idleAbort_pulse", 32'(abortCnt), 32'd0);

    // full load at full rate
    runLoad(0, 0);
    checkAllWrites("full");
    checkVal("full_addr9", 32'(wrAddr[9]), 32'd9);
    checkVal("full_addr10", 32'(wrAddr[10]), 32'd16);
    checkVal("full_addr19", 32'(wrAddr[19]), 32'd25);
    checkVal("full_addr30", 32'(wrAddr[30]), 32'd48);
    checkVal("full_addr39", 32'(wrAddr[39]), 32'd57);
    checkVal("full_data2", 32'(wrData[2]), 32'hFF0E);
    checkVal("full_flagCycles", 32'(flagHigh), 32'd140);
    checkVal("full_doneCnt", 32'(doneCnt), 32'd1);
`ifdef COEFF_CHECKSUM_EN
    sum = '0;
    for (int i = 0; i < 40; i++) sum = sum + coef[i];
    repeat (3) tick();
    checkVal("full_checksum", 32'(oChecksum), 32'(sum));
`else
    sum = '0;
`endif

    // stalled source with stray load requests while busy
    runLoad(1, 0);
    checkAllWrites("stall");
    checkVal("stall_flagWhole", 32'(flagHigh % 20), 32'd0);

    // abort after 15 writes
    a0 = abortCnt;
    runLoad(0, 15);
    tick(); iAbort = 1'b0; iCoeffValid = 1'b0;
    @(negedge iClk12M);
    checkVal("abort_busy", 32'(oBusy), 32'd0);
    checkVal("abort_flag", 32'(oCoeffUpdateFlag), 32'd0);
    checkVal("abort_strobes", {30'd0, oCsnRam, oWrnRam}, 32'd3);
    checkVal("abort_pulse", 32'(oAborted), 32'd1);
    checkVal("abort_writes", 32'(wrAddr.size()), 32'd15);
    checkVal("abort_noDone", 32'(doneCnt), 32'd2);
    runLoad(0, 0);
    checkAllWrites("afterAbort");
    checkVal("afterAbort_firstAddr", 32'(wrAddr[0]), 32'd0);
    checkVal("abort_pulseCount", 32'(abortCnt - a0), 32'd1);

    // load request on the same edge as a strobe: flag waits for the next strobe
    n = 0;
    do begin @(negedge iClk12M); n++; end while (!iEnSample600k && n < 40);
    #1 iLoadReq = 1'b1;
    @(posedge iClk12M); #1 iLoadReq = 1'b0;
    n = 0;
    do begin
      @(posedge iClk12M); n++;
      @(negedge iClk12M);
    end while (!oCoeffUpdateFlag && n < 40);
    checkVal("syncDelay", 32'(n), 32'd20);
    a0 = abortCnt;
    tick(); iAbort = 1'b1;
    tick(); iAbort = 1'b0;
    @(negedge iClk12M);
    checkVal("syncAbort_pulse", 32'(abortCnt - a0), 32'd1);

    // reset pulsed during WRITE
    tick(); iLoadReq = 1'b1; iCoeffValid = 1'b1; iCoeffData = coef[0];
    tick(); iLoadReq = 1'b0;
    n = 0;
    do begin @(negedge iClk12M); n++; end while (oCsnRam && n < 60);
    checkVal("rstWrite_reached", 32'(oCsnRam), 32'd0);
    #1 iRst = 1'b1;
    @(negedge iClk12M);
    checkVal("rstWrite_strobes", {30'd0, oCsnRam, oWrnRam}, 32'd3);
    checkVal("rstWrite_addrData", {10'd0, oAddrRam, oWrDtRam}, 32'd0);
    checkVal("rstWrite_flags", {27'd0, oCoeffUpdateFlag, oCoeffReady, oBusy, oDone, oAborted}, 32'd0);
    tick(); iRst = 1'b0; iCoeffValid = 1'b0;

`ifdef COEFF_CHECKSUM_EN
    for (int i = 0; i < 40; i++) coef[i] = 16'd1;
    runLoad(0, 0);
    repeat (3) tick();
    checkVal("ones_checksum", 32'(oChecksum), 32'd40);
`endif

    checkVal("mon_flagEdges", 32'(flagErr), 32'd0);
    checkVal("mon_singleWrites", 32'(dblErr), 32'd0);
    checkVal("mon_readyOnlyAccept", 32'(readyErr), 32'd0);
    checkVal("mon_writeNeedsHandshake", 32'(hsErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient-update controller for the flexible FIR filter. Accepts a stream of filter coefficients over a valid/ready handshake, maps each linear tap index onto the four-bank coefficient RAM address space, and generates the RAM chip-select, write-enable, address and data signals. It raises the filter's coefficient-update flag only on a 600 kHz sample boundary and holds it until the next boundary after the last write, so taps never change in the middle of a MAC pass.

## Interface
- NUM_TAPS, 40, number of coefficients per load; must be a multiple of TAPS_PER_BANK.
- TAPS_PER_BANK, 10, taps stored per RAM bank.
- BANK_STRIDE, 16, address distance between bank bases; must be ≥ TAPS_PER_BANK.
- DW, 16, coefficient width (two's complement).
- AW, 6, RAM address width.

Ports:
- iClk12M  in  1  12 MHz system clock; all logic is on its rising edge.
- iRst  in  1  Synchronous reset, active-high.
- iEnSample600k  in  1  One-cycle sample strobe, asserted once every 20 clocks.
- iLoadReq  in  1  Starts a load; sampled only in IDLE.
- iAbort  in  1  Cancels a load in progress.
- iCoeffValid  in  1  Coefficient on iCoeffData is valid.
- iCoeffData  in  DW  Coefficient value.
- oCoeffReady  out  1  Loader can accept a coefficient.
- oCoeffUpdateFlag  out  1  Coefficient-update mode flag to the filter.
- oCsnRam  out  1  RAM chip select, active-low.
- oWrnRam  out  1  RAM write enable, active-low.
- oAddrRam  out  AW  RAM address.
- oWrDtRam  out  DW  RAM write data.
- oBusy  out  1  High in every state except IDLE.
- oDone  out  1  One-cycle pulse when a load completes.
- oAborted  out  1  One-cycle pulse when a load is cancelled.
- oChecksum  out  DW  Running coefficient sum; present only with the checksum feature (see Configuration).

## Operation
- All outputs are registered. Reset values: oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, all other outputs 0.
- IDLE: iLoadReq=1 → WAIT_SYNC. The bank and offset counters are cleared on this transition.
- WAIT_SYNC: iEnSample600k=1 → ACCEPT, and oCoeffUpdateFlag is set to 1.
  - A strobe that arrives in the same cycle as iLoadReq (while still in IDLE) does not count.
- ACCEPT: oCoeffReady=1. A handshake (iCoeffValid & oCoeffReady) captures the data and address → WRITE.
- WRITE: oCsnRam=0 and oWrnRam=0 for exactly one cycle, with oAddrRam and oWrDtRam stable → GAP.
- GAP: both strobes high; oAddrRam and oWrDtRam hold; counters advance.
  - If NUM_TAPS coefficients have been written → RELEASE; otherwise → ACCEPT.
- RELEASE: oCoeffUpdateFlag stays 1 until iEnSample600k=1. It is cleared on that edge, oDone pulses for one cycle, → IDLE.
- Address rule: oAddrRam = bank*BANK_STRIDE + offset.
  - offset counts 0…TAPS_PER_BANK-1, then wraps to 0 and bank increments.
  - With defaults: index 0→0, 9→9, 10→16, 19→25, 20→32, 30→48, 39→57.
  - Address arithmetic is AW bits; parameters must keep the maximum address below 2^AW.
- Abort: iAbort=1 in any non-IDLE state → IDLE on the next edge.
  - Strobes go high, oCoeffUpdateFlag goes to 0, oAborted pulses, oDone does not pulse.
  - Any write already issued in WRITE completes in that cycle.
- iAbort and iLoadReq together in IDLE: abort wins, no load starts, no oAborted pulse.
- iLoadReq while oBusy=1: ignored.
- iCoeffValid outside ACCEPT: ignored, no data captured.
- iRst asserted mid-load: every output returns to its reset value on the next edge; the RAM contents left partially written are acceptable.

## Timing
- A load starts 1–20 cycles after iLoadReq, depending on where it falls relative to the next strobe.
- With iCoeffValid held high, each coefficient takes 3 cycles (ACCEPT, WRITE, GAP); 40 taps take 120 cycles.
- The WRITE cycle follows the handshake cycle by exactly 1 clock.
- The flag is set and cleared only on edges where iEnSample600k=1. The flag stays high for a whole number of sample periods (≥ 7 periods for 40 taps at full rate).
- oDone coincides with the clock where oCoeffUpdateFlag falls.

## Configuration
- COEFF_CHECKSUM_EN defined:
  - oChecksum exists and accumulates a DW-bit modulo sum of each written coefficient, updated in WRITE.
  - It clears on IDLE→WAIT_SYNC and on reset, and holds its value after oDone.
- COEFF_CHECKSUM_EN undefined: the oChecksum port and the accumulator are absent; all other behaviour is identical.

## Test plan
- Full load: iLoadReq, iCoeffValid held high, coefficients 146, 0, -242, 302 … (40 values).
  - Expect 40 single-cycle CSn/WRn low pulses at addresses 0–9, 16–25, 32–41, 48–57 with matching data.
  - Expect the flag to rise and fall on strobe edges, and one oDone pulse.
- Stalled source: iCoeffValid toggled every 4 cycles.
  - No write without a handshake; addresses stay contiguous; oCoeffReady is high only in ACCEPT.
- Abort after 15 writes: the next edge gives IDLE, flag=0, CSn=WRn=1, oAborted=1, no oDone.
  - A following full load starts again at address 0.
- iLoadReq on the same edge as iEnSample600k: the flag rises on the following strobe, 20 cycles later, not immediately.
- iRst pulsed during WRITE: all outputs at reset values next cycle; iLoadReq pulses while busy have no effect.
- COEFF_CHECKSUM_EN: the 40-tap load gives oChecksum equal to the modulo-2^16 sum of the inputs.
  - With 40 coefficients of value 1, oChecksum=40.
